fifo_sync: RTL and testbench
============================

# fifo_sync

Synchronous first-in-first-out buffer, the queue-ordered counterpart to the team's push/pop stack, sharing its push/pop/data_in/data_out/empty/full port style. Words leave in arrival order, not reverse order. The block sits between a producer and a consumer in the same clock domain. It adds occupancy count, almost-full/almost-empty thresholds, and sticky overflow/underflow error flags for rate-matching paths.

## Interface
- WIDTH, 16, data word width
- DEPTH, 16, number of entries; power of 2, at least 4
- ALMOST_FULL, 14, almost_full asserts when count >= this value
- ALMOST_EMPTY, 2, almost_empty asserts when count <= this value
- AW, $clog2(DEPTH), derived; not overridden
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- push  in  1  write request
- pop  in  1  read request
- data_in  in  WIDTH  write data, sampled on an accepted push
- clr_err  in  1  synchronous clear of overflow/underflow
- data_out  out  WIDTH  registered read data
- empty  out  1  registered, count==0
- full  out  1  registered, count==DEPTH
- almost_full  out  1  registered
- almost_empty  out  1  registered
- count  out  AW+1  registered occupancy, range 0..DEPTH
- overflow  out  1  sticky error flag
- underflow  out  1  sticky error flag

## Operation
- Accept logic is combinational from the current registered state:
  - rd_ok = pop && !empty
  - wr_ok = push && (!full || pop)
- rd_ok: data_out <= mem[rd_ptr]; rd_ptr increments.
- wr_ok: mem[wr_ptr] <= data_in; wr_ptr increments.
- Both pointers are AW bits wide and wrap modulo DEPTH with no special case.
- count update:
  - +1 on wr_ok && !rd_ok
  - -1 on rd_ok && !wr_ok
  - unchanged otherwise
- empty, full, almost_full and almost_empty are computed from count_next and registered, so they describe post-edge state.
- Boundary cases:
  - Push while full, no pop: dropped; overflow <= 1; no state change.
  - Push+pop while full: both accepted; count stays DEPTH; wr_ptr==rd_ptr. Memory must return the old word (read-before-write).
  - Pop while empty: rejected; underflow <= 1; data_out holds.
  - Push+pop while empty: push accepted, pop rejected; underflow <= 1; count becomes 1.
  - Push+pop at count==1: the old word goes to data_out, the new word is stored, and count stays 1.
- Error flags:
  - overflow and underflow stay set until clr_err.
  - clr_err has priority over a same-cycle set, so the flag ends at 0.
- data_out holds its value on every cycle without rd_ok.
- rst_n low, at any time and mid-operation: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0.
  - Memory contents are not reset; previously stored words are unreachable after reset.

## Timing
- Read latency is 1 cycle: with pop accepted at edge N, data_out is valid after edge N and holds until the next accepted pop.
- Write-to-read latency is 1 cycle: a word pushed into an empty FIFO at edge N clears empty after edge N. A pop at edge N+1 returns it.
- Every output is a flop; there is no combinational path from any input to any output.
- Reset assertion is asynchronous. Deassertion is assumed synchronized upstream; the first push is accepted on the first edge with rst_n high.

## Structure
- Shared package fifo_pkg holds:
  - default constants FIFO_WIDTH=16 and FIFO_DEPTH=16
  - a clog2 helper function
- One sub-module, fifo_mem: simple dual-port RAM with these properties:
  - separate write address and read address
  - synchronous write and synchronous registered read
  - read-before-write on an address collision
- Pointers, count, flags and error logic live in fifo_sync.

## Test plan
- Reset, then push 0x0001..0x0010 (16 words) -> full=1 and count=16 after the 16th edge, almost_full=1 from count 14. A 17th push sets overflow=1 with count still 16.
- Pop 16 times -> data_out is 0x0001..0x0010 in order, one per cycle; empty=1 after the last pop. A 17th pop sets underflow=1 and data_out stays 0x0010.
- Full FIFO, push 0xBEEF with simultaneous pop -> data_out equals the oldest word and count stays 16. After 15 more pops, the 16th pop returns 0xBEEF.
- Empty FIFO, push 0x1234 with simultaneous pop -> count=1, underflow=1, data_out unchanged. The next pop returns 0x1234.
- Fill to 10 entries, drain to 2, refill 20 words while draining so pointers wrap twice -> output sequence matches a reference queue exactly; almost_empty and almost_full toggle at counts 2 and 14.
- With overflow set, assert rst_n low mid-burst and clr_err in another run -> every output returns to its reset value immediately, and the flag clears one edge after clr_err.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH = 16;

    // Ceiling log2; returns 0 for an input of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read, read-before-write.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register; samples the pre-edge word so a same-address write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Synchronous FIFO with occupancy count, threshold flags and sticky error flags.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH        = FIFO_WIDTH,
    parameter int unsigned DEPTH        = FIFO_DEPTH,
    parameter int unsigned ALMOST_FULL  = 14,
    parameter int unsigned ALMOST_EMPTY = 2,
    parameter int unsigned AW           = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_ok_c;
    logic          wr_ok_c;
    logic [CW-1:0] count_next_c;

    // Accept decisions and next occupancy from the registered state.
    always_comb begin
        rd_ok_c      = pop && !empty;
        wr_ok_c      = push && (!full || pop);
        count_next_c = count;
        if (wr_ok_c && !rd_ok_c) begin
            count_next_c = count + CW'(1);
        end else if (rd_ok_c && !wr_ok_c) begin
            count_next_c = count - CW'(1);
        end
    end

    // Pointers, occupancy and status flags describing post-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_next_c;
            empty        <= (count_next_c == '0);
            full         <= (count_next_c == CW'(DEPTH));
            almost_full  <= (count_next_c >= CW'(ALMOST_FULL));
            almost_empty <= (count_next_c <= CW'(ALMOST_EMPTY));
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !wr_ok_c) begin
                overflow <= 1'b1;
            end
            if (pop && !rd_ok_c) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok_c),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_ok_c),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: queue reference model plus directed checks.
module tb_fifo_sync;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic        clr_err = 1'b0;
    logic [15:0] data_out;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    // Reference model state
    logic [15:0] q[$];
    logic [15:0] m_dout;
    logic        m_ovf;
    logic        m_udf;

    fifo_sync dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: words leave in arrival order, errors are sticky.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_dout = 16'h0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            bit was_full;
            bit was_empty;
            bit rd;
            bit wr;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            rd = pop && !was_empty;
            wr = push && (!was_full || pop);
            if (rd) m_dout = q.pop_front();
            if (wr) q.push_back(data_in);
            if (clr_err) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (push && !wr) m_ovf = 1'b1;
                if (pop && !rd)  m_udf = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_data_out", 32'(data_out), 32'(m_dout));
            chk("cmp_count", 32'(count), 32'(q.size()));
            chk("cmp_empty", 32'(empty), 32'(q.size() == 0));
            chk("cmp_full", 32'(full), 32'(q.size() == DEPTH));
            chk("cmp_almost_full", 32'(almost_full), 32'(q.size() >= 14));
            chk("cmp_almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
            chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
            chk("cmp_underflow", 32'(underflow), 32'(m_udf));
        end
    end

    // Apply one cycle of inputs; returns on the following falling edge.
    task automatic cyc(input logic p, input logic r, input logic [15:0] d, input logic c);
        push    = p;
        pop     = r;
        data_in = d;
        clr_err = c;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'h0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
        chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Fill with 0x0001..0x0010
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 16'(i), 1'b0);
            if (i == 13) chk("af_at_13", 32'(almost_full), 32'd0);
            if (i == 14) chk("af_at_14", 32'(almost_full), 32'd1);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        cyc(1'b1, 1'b0, 16'h0099, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 16'h0, 1'b0);
            chk("drain_data", 32'(data_out), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b1, 16'h0, 1'b0);
        chk("udf_set", 32'(underflow), 32'd1);
        chk("udf_hold", 32'(data_out), 32'h0010);

        // clr_err clears one edge later and beats a same-cycle set
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_udf", 32'(underflow), 32'd0);
        cyc(1'b0, 1'b1, 16'h0, 1'b1);
        chk("clr_priority", 32'(underflow), 32'd0);

        // Push+pop while full returns the oldest word
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 16'(16'h0100 + i), 1'b0);
        cyc(1'b1, 1'b1, 16'hBEEF, 1'b0);
        chk("full_pp_data", 32'(data_out), 32'h0101);
        chk("full_pp_count", 32'(count), 32'd16);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 16'h0, 1'b0);
        chk("full_pp_15th", 32'(data_out), 32'h0110);
        cyc(1'b0, 1'b1, 16'h0, 1'b0);
        chk("full_pp_beef", 32'(data_out), 32'hBEEF);

        // Push+pop while empty: push only, underflow set
        cyc(1'b1, 1'b1, 16'h1234, 1'b0);
        chk("empty_pp_count", 32'(count), 32'd1);
        chk("empty_pp_udf", 32'(underflow), 32'd1);
        chk("empty_pp_hold", 32'(data_out), 32'hBEEF);
        cyc(1'b0, 1'b1, 16'h0, 1'b0);
        chk("empty_pp_next", 32'(data_out), 32'h1234);

        // Push+pop at count 1
        cyc(1'b1, 1'b0, 16'h0055, 1'b1);
        cyc(1'b1, 1'b1, 16'h0066, 1'b0);
        chk("one_pp_data", 32'(data_out), 32'h0055);
        chk("one_pp_count", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, 16'h0, 1'b0);
        chk("one_pp_next", 32'(data_out), 32'h0066);

        // Fill 10, drain to 2, then refill while draining
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'(16'h0200 + i), 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 16'h0, 1'b0);
        chk("mix_count2", 32'(count), 32'd2);
        chk("mix_ae2", 32'(almost_empty), 32'd1);
        chk("mix_data", 32'(data_out), 32'h0207);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'(i % 3 == 2), 16'(16'h0300 + i), 1'b0);
        chk("mix_count16", 32'(count), 32'd16);
        chk("mix_af", 32'(almost_full), 32'd1);
        cyc(1'b1, 1'b0, 16'h0DEF, 1'b0);
        chk("mix_ovf", 32'(overflow), 32'd1);

        // Asynchronous reset in the middle of a burst
        push = 1'b1;
        pop = 1'b1;
        data_in = 16'h0AAA;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        push = 1'b0;
        pop = 1'b0;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 16'h0077, 1'b0);
        chk("post_rst_count", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, 16'h0, 1'b0);
        chk("post_rst_data", 32'(data_out), 32'h0077);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
